// File: rtl/bsh_rr_scheduler_if.sv
// Handshake bundle between the client engines and the shared rotate scheduler.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_data/req_sh     : packed operands and shift amounts, requester i in slice i
//   rsp_valid/rsp_ready : result handshake toward the downstream consumer
//   rsp_data/rsp_id     : rotated result and the index of the requester it belongs to
//   busy                : result stage occupied
// master = client/consumer side, slave = scheduler side.
interface bsh_rr_scheduler_if #(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned SH_WIDTH = 3,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*A_WIDTH-1:0]  req_data;
  logic [NUM_REQ*SH_WIDTH-1:0] req_sh;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [A_WIDTH-1:0]          rsp_data;
  logic [ID_WIDTH-1:0]         rsp_id;
  logic                        busy;

  modport master (
    output req_valid, req_data, req_sh, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_sh, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/bsh_rr_scheduler.sv
// Round-robin scheduler in front of a single rotate-left barrel shifter.
// Grants one requester per cycle, rotates its operand left by (sh mod A_WIDTH)
// and holds the result in a single registered stage tagged with the requester id.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of bsh_rr_scheduler_if (request handshake, result handshake, busy)
module bsh_rr_scheduler #(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned SH_WIDTH = 3,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bsh_rr_scheduler_if.slave     bus
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned AmtW = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StFull} state_e;

  state_e              r_state, w_state_next;
  logic [PtrW-1:0]     r_ptr, w_ptr_next;
  logic [PtrW-1:0]     w_gnt_idx;
  logic                w_gnt_found;
  logic                w_rsp_valid;
  logic                w_can_accept;
  logic                w_xfer;
  logic [A_WIDTH-1:0]  r_data;
  logic [ID_WIDTH-1:0] r_id;
  logic [A_WIDTH-1:0]  w_sel_data;
  logic [SH_WIDTH-1:0] w_sel_sh;
  logic [AmtW-1:0]     w_amt;
  logic [A_WIDTH-1:0]  w_rot;

  assign w_rsp_valid  = (r_state == StFull);
  assign w_can_accept = !w_rsp_valid || bus.rsp_ready;
  assign w_xfer       = w_gnt_found && w_can_accept;

  // First valid requester at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    logic [PtrW-1:0] v_idx;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    v_idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = PtrW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_gnt_found && bus.req_valid[v_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = v_idx;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_data = '0;
    w_sel_sh   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == PtrW'(i)) begin
        w_sel_data = bus.req_data[i*A_WIDTH +: A_WIDTH];
        w_sel_sh   = bus.req_sh[i*SH_WIDTH +: SH_WIDTH];
      end
    end
  end

  // Funnel shift of {A,A}; the upper half is the rotate-left result.
  assign w_amt = AmtW'(32'(w_sel_sh) % A_WIDTH);
  assign w_rot = A_WIDTH'(({w_sel_data, w_sel_data} << w_amt) >> A_WIDTH);

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = w_xfer && (w_gnt_idx == PtrW'(i));
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    if (w_xfer) begin
      w_ptr_next = PtrW'((32'(w_gnt_idx) + 1) % NUM_REQ);
    end
    unique case (r_state)
      StIdle: if (w_xfer) w_state_next = StFull;
      StFull: begin
        // Reload on the same edge when the consumer drains and a new op transfers.
        if (w_xfer)             w_state_next = StFull;
        else if (bus.rsp_ready) w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_xfer) begin
        r_data <= w_rot;
        r_id   <= ID_WIDTH'(w_gnt_idx);
      end
    end
  end

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.busy      = w_rsp_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_id    = r_id;

endmodule

// File: tb/tb_bsh_rr_scheduler.sv
module tb_bsh_rr_scheduler;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bsh_rr_scheduler_if #(.A_WIDTH(8),  .SH_WIDTH(3), .NUM_REQ(4), .ID_WIDTH(2)) bus_a ();
  bsh_rr_scheduler_if #(.A_WIDTH(12), .SH_WIDTH(4), .NUM_REQ(4), .ID_WIDTH(2)) bus_b ();

  bsh_rr_scheduler #(.A_WIDTH(8), .SH_WIDTH(3), .NUM_REQ(4), .ID_WIDTH(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bsh_rr_scheduler #(.A_WIDTH(12), .SH_WIDTH(4), .NUM_REQ(4), .ID_WIDTH(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected rotate results for the round-robin step (data/sh set below).
  logic [7:0] rr_exp [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.req_sh = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.req_sh = '0; bus_b.rsp_ready = 1'b1;
    rr_exp[0] = 8'h02; rr_exp[1] = 8'h01; rr_exp[2] = 8'h0F; rr_exp[3] = 8'h1E;

    // Reset state
    tick();
    tick();
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(bus_a.rsp_data),  32'h0);
    chk("rst_rsp_id",    32'(bus_a.rsp_id),    32'h0);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'h0);
    chk("rst_busy",      32'(bus_a.busy),      32'h0);
    rst = 1'b0;

    // Single op: B4 rol 3 = A5
    bus_a.rsp_ready = 1'b1;
    bus_a.req_data[7:0] = 8'hB4;
    bus_a.req_sh[2:0]   = 3'd3;
    bus_a.req_valid     = 4'b0001;
    #1;
    chk("single_req_ready", 32'(bus_a.req_ready), 32'h1);
    tick();
    bus_a.req_valid = 4'b0000;
    #1;
    chk("single_rsp_valid", 32'(bus_a.rsp_valid), 32'h1);
    chk("single_busy",      32'(bus_a.busy),      32'h1);
    chk("single_rsp_data",  32'(bus_a.rsp_data),  32'hA5);
    chk("single_rsp_id",    32'(bus_a.rsp_id),    32'h0);
    tick();
    chk("drain_rsp_valid",  32'(bus_a.rsp_valid), 32'h0);

    // Non-power-of-two width: rotate amount taken mod 12
    bus_b.req_data[11:0] = 12'h801;
    bus_b.req_sh[3:0]    = 4'd13;
    bus_b.req_valid      = 4'b0001;
    tick();
    chk("w12_sh13", 32'(bus_b.rsp_data), 32'h003);
    chk("w12_id",   32'(bus_b.rsp_id),   32'h0);
    bus_b.req_sh[3:0] = 4'd12;
    tick();
    chk("w12_sh12", 32'(bus_b.rsp_data), 32'h801);
    bus_b.req_sh[3:0] = 4'd15;
    tick();
    chk("w12_sh15", 32'(bus_b.rsp_data), 32'h00C);
    bus_b.req_valid = 4'b0000;

    // Pointer back to 0, then all four continuously valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.req_data = {8'h3C, 8'hF0, 8'h80, 8'h01};
    bus_a.req_sh   = {3'd7, 3'd4, 3'd1, 3'd1};
    bus_a.req_valid = 4'b1111;
    #1;
    chk("rr_first_ready", 32'(bus_a.req_ready), 32'h1);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_rsp_valid", 32'(bus_a.rsp_valid), 32'h1);
      chk("rr_rsp_id",    32'(bus_a.rsp_id),    32'(c % 4));
      chk("rr_rsp_data",  32'(bus_a.rsp_data),  32'(rr_exp[c % 4]));
      chk("rr_req_ready", 32'(bus_a.req_ready), 32'(1 << ((c + 1) % 4)));
    end

    // Backpressure: result frozen (id 3, 1E), nobody accepted
    bus_a.rsp_ready = 1'b0;
    bus_a.req_data[15:8]  = 8'hC3; bus_a.req_sh[5:3] = 3'd2;
    bus_a.req_data[23:16] = 8'h5A; bus_a.req_sh[8:6] = 3'd5;
    bus_a.req_valid = 4'b0110;
    #1;
    chk("hold_req_ready0", 32'(bus_a.req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_rsp_valid", 32'(bus_a.rsp_valid), 32'h1);
      chk("hold_rsp_data",  32'(bus_a.rsp_data),  32'h1E);
      chk("hold_rsp_id",    32'(bus_a.rsp_id),    32'h3);
      chk("hold_req_ready", 32'(bus_a.req_ready), 32'h0);
    end
    bus_a.rsp_ready = 1'b1;
    #1;
    chk("release_req1_ready", 32'(bus_a.req_ready), 32'h2);
    tick();
    bus_a.req_valid = 4'b0100;
    #1;
    chk("release_rsp_id1",    32'(bus_a.rsp_id),    32'h1);
    chk("release_rsp_data1",  32'(bus_a.rsp_data),  32'h0F);
    chk("release_req2_ready", 32'(bus_a.req_ready), 32'h4);
    tick();
    chk("release_rsp_id2",   32'(bus_a.rsp_id),   32'h2);
    chk("release_rsp_data2", 32'(bus_a.rsp_data), 32'h4B);

    // Reset while holding a stalled result
    bus_a.rsp_ready = 1'b0;
    bus_a.req_valid = 4'b1111;
    #1;
    chk("prerst_busy",      32'(bus_a.busy),      32'h1);
    chk("prerst_req_ready", 32'(bus_a.req_ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus_a.rsp_valid), 32'h0);
    chk("midrst_rsp_data",  32'(bus_a.rsp_data),  32'h0);
    chk("midrst_busy",      32'(bus_a.busy),      32'h0);
    chk("midrst_req_ready", 32'(bus_a.req_ready), 32'h1);
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.req_valid = 4'b0000;
    #1;
    chk("postrst_rsp_id",   32'(bus_a.rsp_id),   32'h0);
    chk("postrst_rsp_data", 32'(bus_a.rsp_data), 32'h02);
    tick();
    chk("final_idle", 32'(bus_a.rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
